// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types for the two-requester data memory arbiter.
//            Holds the FSM state encoding, the grant identifier and the
//            round-robin pick function used by rr_arbiter2.
// Ports    : (package, none)
// Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } grant_e;

  // Value of last_grant after reset; makes m0 win the first tie.
  localparam grant_e RESET_LAST_GRANT = GNT_M1;

  // Two-way round-robin pick. req[0] belongs to m0, req[1] to m1.
  // With no request the result is a don't-care; m0 is returned.
  function automatic grant_e rr_pick(input logic [1:0] req, input grant_e last);
    grant_e pick;
    case (req)
      2'b01:   pick = GNT_M0;
      2'b10:   pick = GNT_M1;
      2'b11:   pick = (last == GNT_M0) ? GNT_M1 : GNT_M0;
      default: pick = GNT_M0;
    endcase
    return pick;
  endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter_if
// Purpose  : Request/response bundle between one requester and the arbiter.
// Signals  : req   level request, held until ack
//            we    1 = write, 0 = read (stable while req)
//            addr  word address (stable while req)
//            wdata write data (stable while req)
//            ack   one-cycle completion pulse
//            rdata read data, valid with ack on a read
// Modports : master (requester side), slave (arbiter side)
// Revision : 1.0  initial release
// ============================================================================
interface data_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface : data_mem_arbiter_if
`default_nettype wire

// File: rtl/data_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Combinational two-way round-robin selector.
// Ports    : req[1:0]   request vector (bit 0 = m0, bit 1 = m1)
//            last_grant requester granted most recently
//            valid      at least one request present
//            winner     selected requester (meaningful only when valid)
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     last_grant,
  output logic       valid,
  output grant_e     winner
);

  always_comb begin
    valid  = |req;
    winner = rr_pick(req, last_grant);
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Purpose  : Shares one single-port data memory between requester m0 (CPU
//            load/store) and m1 (debug/DMA loader). Round-robin arbitration,
//            one access in flight, registered memory command outputs.
//            The memory acts on the falling clock edge and registers its
//            read data; every access takes IDLE -> ACCESS -> DONE.
// Ports    : clk        clock, all state changes on the rising edge
//            rst_n      asynchronous active-low reset
//            m0, m1     requester bundles (slave side)
//            mem_addr   memory address
//            mem_wdata  memory write data
//            mem_write  memory write strobe
//            mem_read   memory read strobe
//            mem_rdata  memory read data
//            busy       high whenever the FSM is not in IDLE
// Revision : 1.0  initial release
// ============================================================================
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
)(
  input  logic                  clk,
  input  logic                  rst_n,
  data_mem_arbiter_if.slave     m0,
  data_mem_arbiter_if.slave     m1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  // --------------------------------------------------------------------------
  // State and registers
  // --------------------------------------------------------------------------
  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  grant_e                r_last_grant;
  grant_e                r_gnt;
  logic                  r_m0_ack;
  logic                  r_m1_ack;
  logic [DATA_WIDTH-1:0] r_m0_rdata;
  logic [DATA_WIDTH-1:0] r_m1_rdata;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic                  w_arb_valid;
  grant_e                w_arb_winner;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  rr_arbiter2 u_rr (
    .req        ({m1.req, m0.req}),
    .last_grant (r_last_grant),
    .valid      (w_arb_valid),
    .winner     (w_arb_winner)
  );

  // Command of the winning requester, captured on the grant edge.
  always_comb begin
    if (w_arb_winner == GNT_M1) begin
      w_sel_we    = m1.we;
      w_sel_addr  = m1.addr;
      w_sel_wdata = m1.wdata;
    end else begin
      w_sel_we    = m0.we;
      w_sel_addr  = m0.addr;
      w_sel_wdata = m0.wdata;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_arb_valid) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs / datapath controls
  // --------------------------------------------------------------------------
  logic w_grant_load;
  logic w_access_end;
  logic w_done_end;

  always_comb begin
    w_grant_load = 1'b0;
    w_access_end = 1'b0;
    w_done_end   = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_load = w_arb_valid;
      end
      ACCESS: begin
        w_access_end = 1'b1;
        busy         = 1'b1;
      end
      DONE: begin
        w_done_end = 1'b1;
        busy       = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Command and response registers
  // --------------------------------------------------------------------------
  // The strobe is held for the whole ACCESS cycle so the memory sees a
  // stable command at the mid-cycle falling edge; its registered read data
  // is therefore valid at the following rising edge, where it is captured.
  // The async reset drops the strobes immediately, so a reset asserted
  // before that falling edge suppresses the memory access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_write    <= 1'b0;
      mem_read     <= 1'b0;
      r_gnt        <= GNT_M0;
      r_last_grant <= RESET_LAST_GRANT;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      if (w_grant_load) begin
        mem_addr     <= w_sel_addr;
        mem_wdata    <= w_sel_wdata;
        mem_write    <= w_sel_we;
        mem_read     <= !w_sel_we;
        r_gnt        <= w_arb_winner;
        r_last_grant <= w_arb_winner;
      end

      if (w_access_end) begin
        mem_write <= 1'b0;
        mem_read  <= 1'b0;
        if (r_gnt == GNT_M0) begin
          r_m0_ack <= 1'b1;
          if (mem_read) r_m0_rdata <= mem_rdata;
        end else begin
          r_m1_ack <= 1'b1;
          if (mem_read) r_m1_rdata <= mem_rdata;
        end
      end

      if (w_done_end) begin
        r_m0_ack <= 1'b0;
        r_m1_ack <= 1'b0;
      end
    end
  end

  assign m0.ack   = r_m0_ack;
  assign m1.ack   = r_m1_ack;
  assign m0.rdata = r_m0_rdata;
  assign m1.rdata = r_m1_rdata;

endmodule : data_mem_arbiter
`default_nettype wire
